// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state type and default timing for the button debouncer
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESSED   = 2'd1,
        REPEATING = 2'd2
    } btn_state_t;

    // Defaults assume a 1 kHz tick
    localparam int DEF_NUM_BTN      = 5;
    localparam int DEF_STABLE_TICKS = 20;
    localparam int DEF_HOLD_TICKS   = 500;
    localparam int DEF_REPEAT_TICKS = 150;
    localparam int DEF_REPEAT_EN    = 1;

    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_core.sv
// rtl/btn_debounce_core.sv - one button: synchronizer, stability counter, hold/repeat FSM
module btn_debounce_core
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int REPEAT_EN    = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int SW   = cnt_width(STABLE_TICKS + 1);
    localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HW   = cnt_width(HMAX);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_TICKS - 1);

    logic          sync_meta;
    logic          sync_q;
    logic [SW-1:0] stab_cnt;
    logic          accept;

    btn_state_t    state_q, state_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic          level_d, press_d, release_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
        end
    end

    always_comb begin
        accept = tick && (sync_q != btn_level) && (stab_cnt == STABLE_LAST);
    end

    // Any cycle agreeing with the current level restarts the stability window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stab_cnt <= '0;
        end else if (sync_q == btn_level) begin
            stab_cnt <= '0;
        end else if (tick) begin
            stab_cnt <= accept ? '0 : stab_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RELEASED;
            hold_cnt    <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt    <= hold_d;
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end

    // Accept is tested first in the held states so a release beats a same-cycle repeat
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_cnt;
        level_d   = btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (accept) begin
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hold_d  = '0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (accept) begin
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    hold_d    = '0;
                    state_d   = RELEASED;
                end else if (tick) begin
                    if ((REPEAT_EN != 0) && (hold_cnt == HOLD_LAST)) begin
                        press_d = 1'b1;
                        hold_d  = '0;
                        state_d = REPEATING;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
            end
            REPEATING: begin
                if (accept) begin
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    hold_d    = '0;
                    state_d   = RELEASED;
                end else if (tick) begin
                    if (hold_cnt == REPEAT_LAST) begin
                        press_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = RELEASED;
                hold_d  = '0;
                level_d = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/button_tick_debouncer.sv
// rtl/button_tick_debouncer.sv - tick-timed debouncer with press/release/auto-repeat pulses
module button_tick_debouncer
    import btn_pkg::*;
#(
    parameter int NUM_BTN      = DEF_NUM_BTN,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int REPEAT_EN    = DEF_REPEAT_EN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce_core #(
            .STABLE_TICKS (STABLE_TICKS),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS),
            .REPEAT_EN    (REPEAT_EN)
        ) u_core (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule
